// File: rtl/pre_if_stage_pkg.sv
// Shared pipeline definitions for the pre-IF stage.
// Holds the reset vector, the pre-IF FSM state encoding and the redirect
// priority encoding, plus a helper that picks the winning redirect source.
package pre_if_stage_pkg;

  localparam logic [31:0] ResetVector = 32'h1C00_0000;
  // pc resets one word below the vector so the first nextpc (pc+4) is the vector
  localparam logic [31:0] ResetPc     = ResetVector - 32'd4;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StRun       = 2'd1,
    StRedirPend = 2'd2
  } preif_state_e;

  typedef enum logic [1:0] {
    RedirNone = 2'd0,
    RedirExcp = 2'd1,
    RedirErtn = 2'd2,
    RedirBr   = 2'd3
  } redir_sel_e;

  // Exception beats exception-return beats branch.
  function automatic redir_sel_e redir_select(input logic excp, input logic ertn,
                                              input logic br);
    if (excp) begin
      return RedirExcp;
    end else if (ertn) begin
      return RedirErtn;
    end else if (br) begin
      return RedirBr;
    end
    return RedirNone;
  endfunction

endpackage

// File: rtl/preif_redirect_buf.sv
// Redirect buffer and control FSM for the pre-IF stage.
// Holds a redirect target that arrived while IF was stalled so it can be
// fetched once IF accepts again.
// Ports:
//   clk, resetn         - clock, synchronous active-low reset
//   fs_allow_in         - IF can accept a fetch this cycle
//   redir_valid_i       - some live redirect is asserted this cycle
//   redir_target_i      - target of the highest-priority live redirect
//   to_fs_valid_o       - stage out of reset (state != IDLE)
//   pend_o              - a buffered redirect is waiting (REDIR_PEND)
//   buf_target_o        - buffered redirect target
module preif_redirect_buf
  import pre_if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        fs_allow_in,
  input  logic        redir_valid_i,
  input  logic [31:0] redir_target_i,
  output logic        to_fs_valid_o,
  output logic        pend_o,
  output logic [31:0] buf_target_o
);

  preif_state_e state_q, state_d;
  logic [31:0]  buf_q, buf_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      buf_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: begin
        state_d = StRun;
      end
      StRun: begin
        if (redir_valid_i && !fs_allow_in) begin
          state_d = StRedirPend;
          buf_d   = redir_target_i;
        end
      end
      StRedirPend: begin
        if (fs_allow_in) begin
          // The fetch this cycle consumes the buffer (or a newer live redirect).
          state_d = StRun;
        end else if (redir_valid_i) begin
          buf_d = redir_target_i;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign to_fs_valid_o = (state_q != StIdle);
  assign pend_o        = (state_q == StRedirPend);
  assign buf_target_o  = buf_q;

endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF stage: generates nextpc, drives the instruction SRAM request and
// holds the pc of the instruction currently in IF.
// Optional feature: define PREIF_ADEF_CHECK_EN to allow misaligned fetch
// addresses and flag them on excp_adef; otherwise nextpc is forced word-aligned
// and excp_adef is tied low.
// Ports:
//   clk, resetn                 - clock, synchronous active-low reset
//   fs_allow_in                 - IF can accept a new fetch
//   br_taken / br_target        - branch redirect
//   excp_flush / excp_entry     - exception redirect (highest priority)
//   ertn_flush / ertn_target    - exception-return redirect
//   to_fs_valid                 - fetch handed to IF is valid
//   pc                          - pc of the instruction in IF
//   excp_adef                   - held pc is misaligned
//   br_taken_cancel             - instruction in IF is wrong-path
//   inst_sram_en/inst_sram_addr - instruction SRAM read request (addr = nextpc)
module pre_if_stage
  import pre_if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        fs_allow_in,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        excp_flush,
  input  logic [31:0] excp_entry,
  input  logic        ertn_flush,
  input  logic [31:0] ertn_target,
  output logic        to_fs_valid,
  output logic [31:0] pc,
  output logic        excp_adef,
  output logic        br_taken_cancel,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr
);

  redir_sel_e  redir_sel;
  logic        redir_valid;
  logic [31:0] live_target;
  logic        pend;
  logic [31:0] buf_target;
  logic [31:0] nextpc;
  logic [31:0] pc_q, pc_d;

  assign redir_sel   = redir_select(excp_flush, ertn_flush, br_taken);
  assign redir_valid = (redir_sel != RedirNone);

  always_comb begin
    live_target = br_target;
    unique case (redir_sel)
      RedirExcp: live_target = excp_entry;
      RedirErtn: live_target = ertn_target;
      RedirBr:   live_target = br_target;
      default:   live_target = br_target;
    endcase
  end

  preif_redirect_buf u_redirect_buf (
    .clk            (clk),
    .resetn         (resetn),
    .fs_allow_in    (fs_allow_in),
    .redir_valid_i  (redir_valid),
    .redir_target_i (live_target),
    .to_fs_valid_o  (to_fs_valid),
    .pend_o         (pend),
    .buf_target_o   (buf_target)
  );

  always_comb begin
    if (redir_valid) begin
      nextpc = live_target;
    end else if (pend) begin
      nextpc = buf_target;
    end else begin
      nextpc = pc_q + 32'd4;
    end
`ifndef PREIF_ADEF_CHECK_EN
    nextpc[1:0] = 2'b00;
`endif
  end

  assign pc_d = fs_allow_in ? nextpc : pc_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc              = pc_q;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_en    = fs_allow_in & resetn;
  assign br_taken_cancel = excp_flush | ertn_flush | br_taken | pend;

`ifdef PREIF_ADEF_CHECK_EN
  assign excp_adef = to_fs_valid & (|pc_q[1:0]);
`else
  assign excp_adef = 1'b0;
`endif

endmodule

// File: tb/tb_pre_if_stage.sv
module tb_pre_if_stage;

  logic        clk = 1'b0;
  logic        resetn, fs_allow_in;
  logic        br_taken, excp_flush, ertn_flush;
  logic [31:0] br_target, excp_entry, ertn_target;
  logic        to_fs_valid, excp_adef, br_taken_cancel, inst_sram_en;
  logic [31:0] pc, inst_sram_addr;

  always #5 clk = ~clk;

  pre_if_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .fs_allow_in     (fs_allow_in),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .excp_flush      (excp_flush),
    .excp_entry      (excp_entry),
    .ertn_flush      (ertn_flush),
    .ertn_target     (ertn_target),
    .to_fs_valid     (to_fs_valid),
    .pc              (pc),
    .excp_adef       (excp_adef),
    .br_taken_cancel (br_taken_cancel),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr)
  );

  typedef struct {
    logic [31:0] addr;
    logic        en;
    logic        cancel;
    logic        valid;
    logic [31:0] pc;
    logic        adef;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   chk_on = 1'b0;

  // Reference model: architectural pc, "out of reset" flag, pending redirect.
  logic [31:0] m_pc  = 32'h1BFF_FFFC;
  logic [31:0] m_buf = 32'h0;
  bit          m_valid = 1'b0;
  bit          m_pend  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("inst_sram_addr", inst_sram_addr, e.addr);
      check("inst_sram_en", {31'b0, inst_sram_en}, {31'b0, e.en});
      check("br_taken_cancel", {31'b0, br_taken_cancel}, {31'b0, e.cancel});
      check("to_fs_valid", {31'b0, to_fs_valid}, {31'b0, e.valid});
      check("pc", pc, e.pc);
      check("excp_adef", {31'b0, excp_adef}, {31'b0, e.adef});
    end
  end

  task automatic cyc(input logic rn, input logic al,
                     input logic br, input logic [31:0] bt,
                     input logic ex, input logic [31:0] ee,
                     input logic er, input logic [31:0] et);
    exp_t        e;
    logic [31:0] tgt, npc;
    bit          live;
    @(posedge clk);
    #1;
    resetn = rn; fs_allow_in = al;
    br_taken = br; br_target = bt;
    excp_flush = ex; excp_entry = ee;
    ertn_flush = er; ertn_target = et;
    live = ex | er | br;
    tgt  = ex ? ee : (er ? et : bt);
    npc  = live ? tgt : (m_pend ? m_buf : m_pc + 32'd4);
`ifndef PREIF_ADEF_CHECK_EN
    npc = npc & 32'hFFFF_FFFC;
`endif
    e.addr   = npc;
    e.en     = al & rn;
    e.cancel = live | m_pend;
    e.valid  = m_valid;
    e.pc     = m_pc;
`ifdef PREIF_ADEF_CHECK_EN
    e.adef   = m_valid && (m_pc[1:0] != 2'b00);
`else
    e.adef   = 1'b0;
`endif
    if (chk_on) exp_q.push_back(e);
    // Advance model to the state after this edge.
    if (!rn) begin
      m_pc = 32'h1BFF_FFFC; m_buf = 32'h0; m_valid = 1'b0; m_pend = 1'b0;
    end else begin
      if (m_valid) begin
        if (!m_pend) begin
          if (live && !al) begin m_pend = 1'b1; m_buf = tgt; end
        end else if (al) begin
          m_pend = 1'b0;
        end else if (live) begin
          m_buf = tgt;
        end
      end
      if (al) m_pc = npc;
      m_valid = 1'b1;
    end
  endtask

  task automatic run(input logic al);
    cyc(1'b1, al, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic branch(input logic al, input logic [31:0] t);
    cyc(1'b1, al, 1'b1, t, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    resetn = 1'b0; fs_allow_in = 1'b0;
    br_taken = 1'b0; br_target = 32'h0;
    excp_flush = 1'b0; excp_entry = 32'h0;
    ertn_flush = 1'b0; ertn_target = 32'h0;
    // Bring DUT state out of X before checking begins.
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_on = 1'b1;

    // Reset state, then release with allow: 1C000000, 04, 08 ...
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (4) run(1'b1);
    // Taken branch with allow
    branch(1'b1, 32'h1C00_0100);
    run(1'b1);
    // Branch while stalled for 3 cycles
    branch(1'b0, 32'h1C00_0200);
    run(1'b0);
    run(1'b0);
    run(1'b1);
    run(1'b1);
    // Exception and branch together
    cyc(1'b1, 1'b1, 1'b1, 32'h1C00_0300, 1'b1, 32'h1C00_8000, 1'b0, 32'h0);
    run(1'b1);
    // Exception return
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1C00_0400);
    run(1'b1);
    // Misaligned target
    branch(1'b1, 32'h1C00_0102);
    run(1'b1);
    // Newer redirect overwrites a pending one; live redirect beats buffer
    branch(1'b0, 32'h1C00_0600);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1C00_0700);
    run(1'b0);
    run(1'b1);
    branch(1'b0, 32'h1C00_0800);
    branch(1'b1, 32'h1C00_0900);
    run(1'b1);
    // pc+4 wraps
    branch(1'b1, 32'hFFFF_FFFC);
    run(1'b1);
    run(1'b1);
    // Reset during a pending redirect
    branch(1'b0, 32'h1C00_0500);
    run(1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    run(1'b1);
    run(1'b1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic rn, al, br, ex, er;
      logic [31:0] bt, ee, et;
      rn = ($urandom_range(0, 59) != 0);
      al = ($urandom_range(0, 9) < 7);
      br = ($urandom_range(0, 9) == 0);
      ex = ($urandom_range(0, 19) == 0);
      er = ($urandom_range(0, 19) == 0);
      bt = $urandom; ee = $urandom; et = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        bt[1:0] = 2'b00; ee[1:0] = 2'b00; et[1:0] = 2'b00;
      end
      cyc(rn, al, br, bt, ex, ee, er, et);
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pre_if_stage.md
PRE_IF_STAGE -- requirements
Module: pre_if_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port resetn  input  1  synchronous reset, active-low.
REQ-003 SHALL have port fs_allow_in  input  1  IF stage can accept a new fetch this cycle.
REQ-004 SHALL have port br_taken  input  1  branch redirect request from ID/EX.
REQ-005 SHALL have port br_target  input  32  branch target address.
REQ-006 SHALL have port excp_flush  input  1  exception redirect request from WB.
REQ-007 SHALL have port excp_entry  input  32  exception entry address.
REQ-008 SHALL have port ertn_flush  input  1  exception-return redirect request from WB.
REQ-009 SHALL have port ertn_target  input  32  exception-return address.
REQ-010 SHALL have port to_fs_valid  output  1  fetch being handed to IF is valid.
REQ-011 SHALL have port pc  output  32  PC of the instruction now held in IF.
REQ-012 SHALL have port excp_adef  output  1  the held pc is misaligned.
REQ-013 SHALL have port br_taken_cancel  output  1  instruction in IF is wrong-path and must be cancelled.
REQ-014 SHALL have port inst_sram_en  output  1  instruction SRAM read enable.
REQ-015 SHALL have port inst_sram_addr  output  32  instruction SRAM read address (nextpc).

Function
REQ-016 SHALL compute nextpc combinationally with priority: excp_flush -> excp_entry; ertn_flush -> ertn_target; br_taken -> br_target; pending redirect -> buffered target; otherwise pc+4.
REQ-017 SHALL add pc+4 modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
REQ-018 SHALL drive inst_sram_addr = nextpc and inst_sram_en = fs_allow_in & resetn, so SRAM read data arrives in the cycle after the request, aligned with pc.
REQ-019 SHALL load pc <= nextpc on a rising edge only when fs_allow_in=1; pc otherwise holds.
REQ-020 SHALL implement FSM states IDLE (reset), RUN and REDIR_PEND.
REQ-021 SHALL transition IDLE->RUN on the first edge with resetn=1; to_fs_valid=0 in IDLE and 1 otherwise.
REQ-022 SHALL, in RUN, when any redirect is asserted with fs_allow_in=0, latch the selected target into a 32-bit buffer and enter REDIR_PEND.
REQ-023 SHALL, in REDIR_PEND, when fs_allow_in=1, fetch from the buffered target (or a newer live redirect, which wins) and return to RUN.
REQ-024 SHALL, in REDIR_PEND, when a new redirect arrives with fs_allow_in=0, overwrite the buffer using REQ-016 priority.
REQ-025 SHALL drive br_taken_cancel = excp_flush | ertn_flush | br_taken | (state==REDIR_PEND).
REQ-026 SHALL ensure that simultaneous excp_flush and br_taken select excp_entry and that the branch is discarded.

Reset
REQ-027 SHALL, while resetn=0, set pc=0x1BFFFFFC, buffer=0, state=IDLE, to_fs_valid=0 and inst_sram_en=0, so the first fetch address is 0x1C000000.
REQ-028 SHALL let reset asserted mid-redirect discard the pending target.

Configuration
REQ-029 SHALL, with macro PREIF_ADEF_CHECK_EN defined, drive excp_adef = |pc[1:0] while to_fs_valid=1.
REQ-030 SHALL, without PREIF_ADEF_CHECK_EN, tie excp_adef to 0 and force nextpc[1:0] to 0.

Structure
REQ-031 SHALL take the reset vector 0x1C000000, the state encoding and the redirect-priority encoding from the shared pipeline package.
REQ-032 SHALL place the redirect buffer plus FSM in sub-module preif_redirect_buf; pre_if_stage holds the pc register and nextpc mux.

Verification
REQ-033 SHALL cover: release resetn with fs_allow_in=1 -> inst_sram_addr 0x1C000000, 0x1C000004, 0x1C000008 on consecutive cycles; pc lags by one.
REQ-034 SHALL cover: br_taken=1, br_target=0x1C000100, fs_allow_in=1 -> next addr 0x1C000100, br_taken_cancel=1 for that cycle.
REQ-035 SHALL cover: br_taken with target 0x1C000200 while fs_allow_in=0 for 3 cycles -> br_taken_cancel held, pc unchanged, first fetch after allow is 0x1C000200.
REQ-036 SHALL cover: excp_flush (entry 0x1C008000) and br_taken (0x1C000300) in the same cycle -> fetch 0x1C008000 only.
REQ-037 SHALL cover: br_target=0x1C000102 with PREIF_ADEF_CHECK_EN defined -> pc=0x1C000102, excp_adef=1; with the macro undefined -> fetch 0x1C000100, excp_adef=0.
REQ-038 SHALL cover: resetn=0 during REDIR_PEND -> after release, fetch resumes at 0x1C000000.
